// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the team's APB master and the register-bank slave.
// The master drives select/strobe/address/data; the slave returns the handshake and read data.
interface apb_slave_regbank_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              pselx;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output pselx, penable, paddr, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  pselx, penable, paddr, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB slave holding a DEPTH x DATA_W register bank with a fixed number of wait states per transfer.
// Out-of-range addresses complete with pslverr; the bank is also exported flat on reg_q.
module apb_slave_regbank #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic                    pclk,
    input  logic                    preset,
    apb_slave_regbank_if.slave      bus,
    output logic [DEPTH*DATA_W-1:0] reg_q
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              addr_valid;
    logic [DATA_W-1:0] rd_sel;

    assign addr_valid = ({1'b0, bus.paddr} < DEPTH_LIM);

    // The counter is reloaded on every SETUP, so it never needs to wrap.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= S_IDLE;
            cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.pselx && !bus.penable) begin
                        cnt   <= CNT_INIT;
                        state <= (WAIT_STATES == 0) ? S_READY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.pselx) begin
                        state <= S_IDLE;
                    end else if (bus.penable) begin
                        if (cnt == '0) begin
                            state <= S_READY;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (bus.pselx && bus.penable && bus.pwrite && addr_valid) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (bus.paddr == ADDR_W'(i)) begin
                                regs[i] <= bus.pwdata;
                            end
                        end
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Compare-based select keeps out-of-range addresses from indexing past the bank.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.paddr == ADDR_W'(i)) begin
                rd_sel = regs[i];
            end
        end
    end

    assign bus.pready  = (state == S_READY);
    assign bus.prdata  = ((state == S_READY) && !bus.pwrite && addr_valid) ? rd_sel : '0;
    assign bus.pslverr = (state == S_READY) && !addr_valid;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench for apb_slave_regbank: a 2-wait-state instance and a zero-wait instance,
// each compared against a plain array model of the register bank.
module tb_apb_slave_regbank;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 12;
    localparam int WS     = 2;
    localparam int FLAT_W = DEPTH * DATA_W;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    apb_slave_regbank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus  ();
    apb_slave_regbank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();

    logic [FLAT_W-1:0] reg_q;
    logic [FLAT_W-1:0] reg_q0;

    apb_slave_regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus),
        .reg_q  (reg_q)
    );

    apb_slave_regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus0),
        .reg_q  (reg_q0)
    );

    logic [DATA_W-1:0] model  [DEPTH];
    logic [DATA_W-1:0] model0 [DEPTH];
    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [FLAT_W-1:0] observed,
                               input logic [FLAT_W-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [FLAT_W-1:0] flatModel(input bit zeroWait);
        logic [FLAT_W-1:0] f = '0;
        for (int i = 0; i < DEPTH; i++) begin
            f[i*DATA_W +: DATA_W] = zeroWait ? model0[i] : model[i];
        end
        return f;
    endfunction

    // Called and returns just after a rising edge; abortAt < 0 runs the full transfer.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic wr,
                                 input logic [DATA_W-1:0] data, input int abortAt);
        bit valid = (int'(addr) < DEPTH);
        logic [DATA_W-1:0] expRead = '0;
        if (valid && !wr) expRead = model[addr];
        bus.pselx = 1'b1; bus.penable = 1'b0;
        bus.paddr = addr; bus.pwrite = wr; bus.pwdata = data;
        @(negedge pclk);
        checkOutput("setup_pready", bus.pready, 0);
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        for (int k = 0; k <= WS; k++) begin
            if (k == abortAt) begin
                bus.pselx = 1'b0; bus.penable = 1'b0;
                @(posedge pclk); #1;
                checkOutput("abort_pready", bus.pready, 0);
                checkOutput("abort_reg_q", reg_q, flatModel(1'b0));
                return;
            end
            @(negedge pclk);
            checkOutput("pready", bus.pready, (k == WS));
            checkOutput("prdata", bus.prdata, (k == WS) ? expRead : '0);
            checkOutput("pslverr", bus.pslverr, (k == WS) && !valid);
            @(posedge pclk); #1;
        end
        if (wr && valid) model[addr] = data;
        bus.pselx = 1'b0; bus.penable = 1'b0;
        checkOutput("post_pready", bus.pready, 0);
        checkOutput("post_prdata", bus.prdata, 0);
        checkOutput("reg_q", reg_q, flatModel(1'b0));
    endtask

    task automatic applyZeroWait(input logic [ADDR_W-1:0] addr, input logic wr,
                                 input logic [DATA_W-1:0] data);
        bit valid = (int'(addr) < DEPTH);
        logic [DATA_W-1:0] expRead = '0;
        if (valid && !wr) expRead = model0[addr];
        bus0.pselx = 1'b1; bus0.penable = 1'b0;
        bus0.paddr = addr; bus0.pwrite = wr; bus0.pwdata = data;
        @(negedge pclk);
        checkOutput("zw_setup_pready", bus0.pready, 0);
        @(posedge pclk); #1;
        bus0.penable = 1'b1;
        @(negedge pclk);
        checkOutput("zw_pready", bus0.pready, 1);
        checkOutput("zw_prdata", bus0.prdata, expRead);
        checkOutput("zw_pslverr", bus0.pslverr, !valid);
        @(posedge pclk); #1;
        if (wr && valid) model0[addr] = data;
        bus0.pselx = 1'b0; bus0.penable = 1'b0;
        checkOutput("zw_post_pready", bus0.pready, 0);
        checkOutput("zw_reg_q", reg_q0, flatModel(1'b1));
    endtask

    task automatic applyIdle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            model0[i] = '0;
        end
        bus.pselx = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0; bus.pwdata = '0;
        bus0.pselx = 1'b0; bus0.penable = 1'b0; bus0.paddr = '0; bus0.pwrite = 1'b0; bus0.pwdata = '0;
        applyIdle(2);
        checkOutput("rst_pready", bus.pready, 0);
        checkOutput("rst_prdata", bus.prdata, 0);
        checkOutput("rst_pslverr", bus.pslverr, 0);
        checkOutput("rst_reg_q", reg_q, 0);
        preset = 1'b0;
        applyIdle(1);

        $display("[TB] directed transfers, %0d wait states", WS);
        applyStimulus(4'd3, 1'b1, 16'hA5C3, -1);
        applyStimulus(4'd3, 1'b0, 16'h0000, -1);
        applyStimulus(4'd13, 1'b1, 16'h1234, -1);
        applyStimulus(4'd13, 1'b0, 16'h0000, -1);
        applyStimulus(4'd11, 1'b1, 16'h7E7E, -1);
        applyStimulus(4'd0, 1'b1, 16'h0001, -1);
        applyStimulus(4'd0, 1'b0, 16'h0000, -1);
        applyIdle(1);
        applyStimulus(4'd5, 1'b1, 16'hBEEF, 1);
        applyIdle(1);

        // ACCESS without a preceding SETUP must be ignored.
        bus.pselx = 1'b1; bus.penable = 1'b1; bus.paddr = 4'd3; bus.pwrite = 1'b1; bus.pwdata = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            checkOutput("nosetup_pready", bus.pready, 0);
        end
        bus.pselx = 1'b0; bus.penable = 1'b0;
        applyIdle(1);
        checkOutput("nosetup_reg_q", reg_q, flatModel(1'b0));

        $display("[TB] randomized transfers");
        for (int n = 0; n < 60; n++) begin
            applyStimulus(ADDR_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), DATA_W'($urandom),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WS)) : -1);
            if ($urandom_range(0, 3) == 0) applyIdle(int'($urandom_range(1, 2)));
        end

        $display("[TB] zero-wait instance");
        applyZeroWait(4'd3, 1'b1, 16'hA5C3);
        applyZeroWait(4'd3, 1'b0, 16'h0000);
        applyZeroWait(4'd13, 1'b1, 16'h1234);
        applyZeroWait(4'd12, 1'b0, 16'h0000);
        for (int n = 0; n < 20; n++) begin
            applyZeroWait(ADDR_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), DATA_W'($urandom));
        end

        $display("[TB] reset mid-WAIT");
        applyStimulus(4'd7, 1'b1, 16'hC0DE, -1);
        bus.pselx = 1'b1; bus.penable = 1'b0; bus.paddr = 4'd7; bus.pwrite = 1'b1; bus.pwdata = 16'h5555;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            model0[i] = '0;
        end
        checkOutput("midrst_pready", bus.pready, 0);
        checkOutput("midrst_prdata", bus.prdata, 0);
        checkOutput("midrst_pslverr", bus.pslverr, 0);
        checkOutput("midrst_reg_q", reg_q, 0);
        checkOutput("midrst_reg_q0", reg_q0, 0);
        @(posedge pclk); #1;
        preset = 1'b0;
        @(negedge pclk);
        checkOutput("postrst_pready", bus.pready, 0);
        @(posedge pclk); #1;
        bus.pselx = 1'b0; bus.penable = 1'b0;
        checkOutput("postrst_idle_pready", bus.pready, 0);
        applyStimulus(4'd7, 1'b0, 16'h0000, -1);
        applyStimulus(4'd7, 1'b1, 16'h0F0F, -1);
        applyStimulus(4'd7, 1'b0, 16'h0000, -1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
